// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU control FSM: states, opcode/ext fields,
// writeback and next-PC selects, branch condition codes.
package cpu_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    EXEC    = 4'd2,
    STORE   = 4'd3,
    LOAD_RD = 4'd4,
    LOAD_WB = 4'd5,
    BRANCH  = 4'd6,
    JUMP    = 4'd7,
    JAL     = 4'd8
  } state_t;

  localparam logic [3:0] OP_ALU    = 4'b0000;
  localparam logic [3:0] OP_MEM    = 4'b0100;
  localparam logic [3:0] OP_BRANCH = 4'b1100;

  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STORE = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JUMP  = 4'b1100;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

  localparam logic [1:0] PC_INC  = 2'd0;
  localparam logic [1:0] PC_DISP = 2'd1;
  localparam logic [1:0] PC_REG  = 2'd2;

  // flag bus bit positions {N,Z,F,L,C}
  localparam int FLAG_N = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_L = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [3:0] {
    CC_EQ, CC_NE, CC_CS, CC_CC, CC_HI, CC_LS, CC_GT, CC_LE,
    CC_FS, CC_FC, CC_LO, CC_HS, CC_LT, CC_GE, CC_UC, CC_NV
  } cond_t;

  function automatic logic uses_imm(input logic [3:0] op);
    case (op)
      4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0110,
      4'b0111, 4'b1001, 4'b1010, 4'b1011, 4'b1101: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

  // Memory-class opcodes with an unknown ext fall back to a plain ALU cycle.
  function automatic state_t decode_op(input logic [3:0] op, input logic [3:0] ext);
    if (op == OP_BRANCH) return BRANCH;
    if (op != OP_MEM)    return EXEC;
    case (ext)
      EXT_STORE: return STORE;
      EXT_LOAD:  return LOAD_RD;
      EXT_JUMP:  return JUMP;
      EXT_JAL:   return JAL;
      default:   return EXEC;
    endcase
  endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Memory request/ready handshake between the control FSM and memory.
interface cpu_ctrl_fsm_if;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  logic mem_ready;

  modport master (output mem_req, mem_we, addr_sel, input mem_ready);
  modport slave  (input mem_req, mem_we, addr_sel, output mem_ready);
endinterface

// File: rtl/cond_eval.sv
// Branch/jump condition evaluation of a 4-bit condition code against ALU flags.
module cond_eval
  import cpu_pkg::*;
#(
  parameter int FLAG_W = 5
) (
  input  logic [3:0]        cond,
  input  logic [FLAG_W-1:0] flags,
  output logic              taken
);

  logic n, z, f, l, c;
  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign f = flags[FLAG_F];
  assign l = flags[FLAG_L];
  assign c = flags[FLAG_C];

  always_comb begin
    taken = 1'b0;
    case (cond_t'(cond))
      CC_EQ: taken = z;
      CC_NE: taken = !z;
      CC_CS: taken = c;
      CC_CC: taken = !c;
      CC_HI: taken = l;
      CC_LS: taken = !l;
      CC_GT: taken = n;
      CC_LE: taken = !n;
      CC_FS: taken = f;
      CC_FC: taken = !f;
      CC_LO: taken = !l && !z;
      CC_HS: taken = l || z;
      CC_LT: taken = !n && !z;
      CC_GE: taken = n || z;
      CC_UC: taken = 1'b1;
      CC_NV: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle CPU control FSM: fetch, decode, ALU exec, load/store, branch,
// jump and jump-and-link, with registered Moore outputs.
module cpu_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int REG_COUNT = 16,
  parameter int FLAG_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          instruction,
  input  logic [FLAG_W-1:0]    flags,
  cpu_ctrl_fsm_if.master       mem,
  output logic                 ir_en,
  output logic                 pc_en,
  output logic [1:0]           pc_sel,
  output logic                 imm_sel,
  output logic [1:0]           wb_sel,
  output logic [REG_COUNT-1:0] reg_wen,
  output logic [3:0]           state_o
);

  state_t state, nxt;

  logic [3:0] opcode, rd, ext;
  assign opcode = instruction[15:12];
  assign rd     = instruction[11:8];
  assign ext    = instruction[7:4];

  logic unused_low;
  assign unused_low = ^instruction[3:0];

  logic taken;
  cond_eval #(.FLAG_W(FLAG_W)) u_cond (.cond(rd), .flags(flags), .taken(taken));

  // Destinations beyond REG_COUNT decode to no write at all.
  logic [REG_COUNT-1:0] wen_dec;
  always_comb begin
    wen_dec = '0;
    for (int i = 0; i < REG_COUNT; i++) wen_dec[i] = (rd == 4'(i));
  end

  logic                 mem_req_q, mem_we_q, addr_sel_q, pc_en_q, imm_sel_q;
  logic [1:0]           pc_sel_q, wb_sel_q;
  logic [REG_COUNT-1:0] reg_wen_q;

  // mem_ready only counts while a request is actually outstanding.
  logic mem_done;
  assign mem_done = mem_req_q & mem.mem_ready;

  always_comb begin
    nxt = FETCH;
    case (state)
      FETCH:   nxt = mem_done ? DECODE : FETCH;
      DECODE:  nxt = decode_op(opcode, ext);
      STORE:   nxt = mem_done ? FETCH : STORE;
      LOAD_RD: nxt = mem_done ? LOAD_WB : LOAD_RD;
      default: nxt = FETCH;
    endcase
  end

  // Outputs are registered from the next state, so they equal a Moore decode
  // of the state they accompany.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FETCH;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      addr_sel_q <= 1'b0;
      pc_en_q    <= 1'b0;
      imm_sel_q  <= 1'b0;
      pc_sel_q   <= PC_INC;
      wb_sel_q   <= WB_ALU;
      reg_wen_q  <= '0;
    end else begin
      state      <= nxt;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      addr_sel_q <= 1'b0;
      pc_en_q    <= 1'b0;
      imm_sel_q  <= 1'b0;
      pc_sel_q   <= PC_INC;
      wb_sel_q   <= WB_ALU;
      reg_wen_q  <= '0;
      case (nxt)
        FETCH:   mem_req_q <= 1'b1;
        STORE: begin
          mem_req_q  <= 1'b1;
          mem_we_q   <= 1'b1;
          addr_sel_q <= 1'b1;
        end
        LOAD_RD: begin
          mem_req_q  <= 1'b1;
          addr_sel_q <= 1'b1;
        end
        EXEC: begin
          pc_en_q   <= 1'b1;
          imm_sel_q <= uses_imm(opcode);
          reg_wen_q <= wen_dec;
        end
        LOAD_WB: begin
          pc_en_q   <= 1'b1;
          wb_sel_q  <= WB_MEM;
          reg_wen_q <= wen_dec;
        end
        BRANCH: begin
          pc_en_q  <= 1'b1;
          pc_sel_q <= taken ? PC_DISP : PC_INC;
        end
        JUMP: begin
          pc_en_q  <= 1'b1;
          pc_sel_q <= taken ? PC_REG : PC_INC;
        end
        JAL: begin
          pc_en_q   <= 1'b1;
          pc_sel_q  <= PC_REG;
          wb_sel_q  <= WB_LINK;
          reg_wen_q <= wen_dec;
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_we   = mem_we_q;
  assign mem.addr_sel = addr_sel_q;
  assign ir_en        = (state == FETCH) & mem_done;
  assign pc_en        = pc_en_q | ((state == STORE) & mem_done);
  assign pc_sel       = pc_sel_q;
  assign imm_sel      = imm_sel_q;
  assign wb_sel       = wb_sel_q;
  assign reg_wen      = reg_wen_q;
  assign state_o      = state;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm; a REG_COUNT=8 copy runs in lockstep on the
// same stimulus to cover out-of-range destinations.
module tb_cpu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] instruction = 16'h0000;
  logic [4:0]  flags = 5'b0;
  logic        mem_ready = 1'b0;

  logic        ir_en, pc_en, imm_sel, ir_en8, pc_en8, imm_sel8;
  logic [1:0]  pc_sel, wb_sel, pc_sel8, wb_sel8;
  logic [15:0] reg_wen;
  logic [7:0]  reg_wen8;
  logic [3:0]  state_o, state_o8;

  int n_vec = 0;
  int n_err = 0;

  cpu_ctrl_fsm_if mif ();
  cpu_ctrl_fsm_if mif8 ();
  assign mif.mem_ready  = mem_ready;
  assign mif8.mem_ready = mem_ready;

  cpu_ctrl_fsm #(.REG_COUNT(16), .FLAG_W(5)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .flags(flags), .mem(mif),
    .ir_en(ir_en), .pc_en(pc_en), .pc_sel(pc_sel), .imm_sel(imm_sel),
    .wb_sel(wb_sel), .reg_wen(reg_wen), .state_o(state_o)
  );

  cpu_ctrl_fsm #(.REG_COUNT(8), .FLAG_W(5)) dut8 (
    .clk(clk), .rst(rst), .instruction(instruction), .flags(flags), .mem(mif8),
    .ir_en(ir_en8), .pc_en(pc_en8), .pc_sel(pc_sel8), .imm_sel(imm_sel8),
    .wb_sel(wb_sel8), .reg_wen(reg_wen8), .state_o(state_o8)
  );

  // {state, mem_req, mem_we, addr_sel, ir_en, pc_en, pc_sel, imm_sel, wb_sel}
  wire [13:0] obs = {state_o, mif.mem_req, mif.mem_we, mif.addr_sel, ir_en, pc_en,
                     pc_sel, imm_sel, wb_sel};

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered in FETCH with mem_req up; leaves just after the DECODE->next edge.
  task automatic fetch_decode(input logic [15:0] ins, input string tag);
    logic [13:0] exp;
    instruction = ins;
    mem_ready   = 1'b1;
    #1;
    exp = {4'd0, 5'b10010, 2'd0, 1'b0, 2'd0};
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s_fetch: got %h want %h", tag, obs, exp);
    end
    step();
    mem_ready = 1'b0;
    #1;
    exp = {4'd1, 5'b00000, 2'd0, 1'b0, 2'd0};
    n_vec++;
    if ({obs, reg_wen} !== {exp, 16'h0000}) begin
      n_err++;
      $display("FAIL %s_decode: got %h/%h want %h/0000", tag, obs, reg_wen, exp);
    end
    step();
  endtask

  task automatic test_reset();
    logic [13:0] exp;
    mem_ready = 1'b1;
    #12;
    n_vec++;
    if ({obs, reg_wen, reg_wen8} !== 38'd0) begin
      n_err++;
      $display("FAIL reset_hold: got %h/%h/%h want all zero", obs, reg_wen, reg_wen8);
    end
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if (obs !== 14'd0) begin
      n_err++;
      $display("FAIL reset_release: got %h want 0000", obs);
    end
    step();
    #1;
    exp = {4'd0, 5'b10000, 2'd0, 1'b0, 2'd0};
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL reset_first_fetch: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_exec();
    logic [15:0] ins  [6];
    logic        imm  [6];
    logic [15:0] wen  [6];
    logic [7:0]  wen8 [6];
    logic [13:0] exp;
    ins  = '{16'h0353, 16'h5205, 16'hE100, 16'hD300, 16'h0C53, 16'h1400};
    imm  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    wen  = '{16'h0008, 16'h0004, 16'h0002, 16'h0008, 16'h1000, 16'h0010};
    wen8 = '{8'h08, 8'h04, 8'h02, 8'h08, 8'h00, 8'h10};
    for (int i = 0; i < 6; i++) begin
      fetch_decode(ins[i], "exec");
      #1;
      exp = {4'd2, 5'b00001, 2'd0, imm[i], 2'd0};
      n_vec++;
      if ({obs, reg_wen, reg_wen8, state_o8} !== {exp, wen[i], wen8[i], 4'd2}) begin
        n_err++;
        $display("FAIL exec_%h: got %h/%h/%h/%h want %h/%h/%h/2", ins[i], obs, reg_wen,
                 reg_wen8, state_o8, exp, wen[i], wen8[i]);
      end
      step();
      #1;
      exp = {4'd0, 5'b10000, 2'd0, 1'b0, 2'd0};
      n_vec++;
      if ({obs, reg_wen} !== {exp, 16'h0000}) begin
        n_err++;
        $display("FAIL exec_return_%h: got %h/%h want %h/0000", ins[i], obs, reg_wen, exp);
      end
    end
  endtask

  task automatic test_load();
    logic [13:0] exp;
    fetch_decode(16'h4704, "load");
    exp = {4'd4, 5'b10100, 2'd0, 1'b0, 2'd0};
    for (int c = 0; c < 3; c++) begin
      if (c == 2) mem_ready = 1'b1;
      #1;
      n_vec++;
      if ({obs, reg_wen} !== {exp, 16'h0000}) begin
        n_err++;
        $display("FAIL load_rd_%0d: got %h/%h want %h/0000", c, obs, reg_wen, exp);
      end
      step();
    end
    mem_ready = 1'b0;
    #1;
    exp = {4'd5, 5'b00001, 2'd0, 1'b0, 2'd1};
    n_vec++;
    if ({obs, reg_wen} !== {exp, 16'h0080}) begin
      n_err++;
      $display("FAIL load_wb: got %h/%h want %h/0080", obs, reg_wen, exp);
    end
    step();
  endtask

  task automatic test_store();
    logic [13:0] exp;
    fetch_decode(16'h4340, "store");
    #1;
    exp = {4'd3, 5'b11100, 2'd0, 1'b0, 2'd0};
    n_vec++;
    if ({obs, reg_wen} !== {exp, 16'h0000}) begin
      n_err++;
      $display("FAIL store_wait: got %h/%h want %h/0000", obs, reg_wen, exp);
    end
    step();
    mem_ready = 1'b1;
    #1;
    exp = {4'd3, 5'b11101, 2'd0, 1'b0, 2'd0};
    n_vec++;
    if ({obs, reg_wen} !== {exp, 16'h0000}) begin
      n_err++;
      $display("FAIL store_done: got %h/%h want %h/0000", obs, reg_wen, exp);
    end
    step();
    mem_ready = 1'b0;
    #1;
    exp = {4'd0, 5'b10000, 2'd0, 1'b0, 2'd0};
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL store_return: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_branch();
    logic [15:0] ins [9];
    logic [4:0]  flg [9];
    logic [3:0]  st  [9];
    logic [1:0]  sel [9];
    logic [13:0] exp;
    ins = '{16'hC005, 16'hC005, 16'hCA00, 16'hCA00, 16'hCD00, 16'hC100,
            16'h4EC0, 16'h4FC0, 16'h46C0};
    flg = '{5'b01000, 5'b00000, 5'b00000, 5'b00010, 5'b10000, 5'b01000,
            5'b00000, 5'b11111, 5'b10000};
    st  = '{4'd6, 4'd6, 4'd6, 4'd6, 4'd6, 4'd6, 4'd7, 4'd7, 4'd7};
    sel = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd2};
    for (int i = 0; i < 9; i++) begin
      flags = flg[i];
      fetch_decode(ins[i], "branch");
      #1;
      exp = {st[i], 5'b00001, sel[i], 1'b0, 2'd0};
      n_vec++;
      if ({obs, reg_wen} !== {exp, 16'h0000}) begin
        n_err++;
        $display("FAIL branch_%0d_%h: got %h/%h want %h/0000", i, ins[i], obs, reg_wen, exp);
      end
      step();
    end
    flags = 5'b0;
  endtask

  task automatic test_jal();
    logic [13:0] exp;
    fetch_decode(16'h4F88, "jal");
    #1;
    exp = {4'd8, 5'b00001, 2'd2, 1'b0, 2'd2};
    n_vec++;
    if ({obs, reg_wen, reg_wen8} !== {exp, 16'h8000, 8'h00}) begin
      n_err++;
      $display("FAIL jal: got %h/%h/%h want %h/8000/00", obs, reg_wen, reg_wen8, exp);
    end
    step();
  endtask

  task automatic test_reset_mid_store();
    logic [13:0] exp;
    fetch_decode(16'h4340, "rst_store");
    step();
    rst = 1'b0;
    #1;
    n_vec++;
    if ({obs, reg_wen} !== 30'd0) begin
      n_err++;
      $display("FAIL reset_mid_store: got %h/%h want 0000/0000", obs, reg_wen);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    #1;
    exp = {4'd0, 5'b10000, 2'd0, 1'b0, 2'd0};
    n_vec++;
    if ({obs, reg_wen} !== {exp, 16'h0000}) begin
      n_err++;
      $display("FAIL reset_store_recover: got %h/%h want %h/0000", obs, reg_wen, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_exec();
    test_load();
    test_store();
    test_branch();
    test_jal();
    test_reset_mid_store();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
